// File: rtl/xm_mem_pkg.sv
// Shared types and helpers for the xm_mem_unit memory access unit.
package xm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  localparam int MAX_LANES = 16;

  // One-hot lane for byte accesses, all active lanes for word accesses.
  function automatic logic [MAX_LANES-1:0] byte_enables(input logic [3:0] offset,
                                                        input logic       byte_op,
                                                        input int         lanes);
    logic [MAX_LANES-1:0] all_lanes;
    all_lanes = (MAX_LANES'(1) << lanes) - MAX_LANES'(1);
    return byte_op ? (MAX_LANES'(1) << offset) : all_lanes;
  endfunction

endpackage

// File: rtl/xm_byte_lane_align.sv
// Combinational byte-lane steering: store-data replication and load-lane
// extraction with sign or zero extension.
module xm_byte_lane_align #(
  parameter int WORD = 16
) (
  input  logic [WORD-1:0]               wdata,
  input  logic                          byte_op,
  input  logic                          sign_ext,
  input  logic [$clog2(WORD/8)-1:0]     offset,
  input  logic [WORD-1:0]               rdata_bus,
  output logic [WORD-1:0]               wdata_rep,
  output logic [WORD-1:0]               rdata_ext
);

  localparam int LANES = WORD / 8;

  logic        [7:0]      lane;
  logic signed [7:0]      lane_s;
  logic signed [WORD-1:0] lane_sx;
  logic        [WORD-1:0] lane_zx;

  assign wdata_rep = byte_op ? {LANES{wdata[7:0]}} : wdata;

  assign lane    = rdata_bus[{offset, 3'b000} +: 8];
  assign lane_s  = lane;
  assign lane_sx = WORD'(lane_s);
  assign lane_zx = {{(WORD-8){1'b0}}, lane};

  assign rdata_ext = !byte_op ? rdata_bus :
                     sign_ext ? lane_sx   : lane_zx;

endmodule

// File: rtl/xm_mem_unit.sv
// Memory access unit: one load/store/fetch per request over a req/ack bus.
// Define XM_MEM_RETRY_EN to reissue a timed-out request once before erroring.
module xm_mem_unit
  import xm_mem_pkg::*;
#(
  parameter  int WORD    = 16,
  parameter  int TIMEOUT = 15,
  localparam int LANES   = WORD / 8,
  localparam int LB      = $clog2(LANES)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             wr_i,
  input  logic             byteOp_i,
  input  logic             fetch_i,
  input  logic             signExt_i,
  input  logic             abort_i,
  input  logic [WORD-1:0]  addr_i,
  input  logic [WORD-1:0]  wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       errCode_o,
  output logic [WORD-1:0]  rdata_o,
  output logic [WORD-1:0]  ir_o,
  output logic             memReq_o,
  output logic             memWe_o,
  output logic [LANES-1:0] memBe_o,
  output logic [WORD-LB-1:0] memAddr_o,
  output logic [WORD-1:0]  memWdata_o,
  input  logic [WORD-1:0]  memRdata_i,
  input  logic             memAck_i
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WORD-1:0]      addr_q;
  logic [WORD-1:0]      wdata_q;
  logic                 byte_q;
  logic                 sext_q;
  logic                 fetch_q;
  logic                 we_q;
  logic                 misaligned;
  logic [MAX_LANES-1:0] be_next;
  logic [WORD-1:0]      rdata_ext;
`ifdef XM_MEM_RETRY_EN
  logic                 retried_q;
`endif

  // A fetch is always a word read, so its store/byte/sign controls are masked.
  assign misaligned = (fetch_i || !byteOp_i) && (addr_i[LB-1:0] != '0);
  assign be_next    = byte_enables(4'(addr_i[LB-1:0]), byteOp_i && !fetch_i, LANES);
  assign memAddr_o  = addr_q[WORD-1:LB];
  assign memWe_o    = we_q;

  xm_byte_lane_align #(.WORD(WORD)) u_align (
    .wdata     (wdata_q),
    .byte_op   (byte_q),
    .sign_ext  (sext_q),
    .offset    (addr_q[LB-1:0]),
    .rdata_bus (memRdata_i),
    .wdata_rep (memWdata_o),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_q    <= 1'b0;
      sext_q    <= 1'b0;
      fetch_q   <= 1'b0;
      we_q      <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      errCode_o <= ERR_NONE;
      rdata_o   <= '0;
      ir_o      <= '0;
      memReq_o  <= 1'b0;
      memBe_o   <= '0;
`ifdef XM_MEM_RETRY_EN
      retried_q <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            fetch_q <= fetch_i;
            we_q    <= wr_i && !fetch_i;
            byte_q  <= byteOp_i && !fetch_i;
            sext_q  <= signExt_i && !fetch_i;
            memBe_o <= be_next[LANES-1:0];
            cnt     <= '0;
            busy_o  <= 1'b1;
`ifdef XM_MEM_RETRY_EN
            retried_q <= 1'b0;
`endif
            if (misaligned) begin
              state     <= RESP;
              done_o    <= 1'b1;
              err_o     <= 1'b1;
              errCode_o <= ERR_ALIGN;
            end else begin
              state    <= ACCESS;
              memReq_o <= 1'b1;
            end
          end
        end
        ACCESS: begin
`ifdef XM_MEM_RETRY_EN
          // Request low inside ACCESS is the one-cycle gap before the reissue.
          if (!memReq_o) begin
            if (abort_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              memReq_o <= 1'b1;
            end
          end else
`endif
          if (memAck_i) begin
            if (fetch_q)
              ir_o <= memRdata_i;
            else if (!we_q)
              rdata_o <= rdata_ext;
            memReq_o  <= 1'b0;
            state     <= RESP;
            done_o    <= 1'b1;
            errCode_o <= ERR_NONE;
          end else if (abort_i) begin
            memReq_o <= 1'b0;
            state    <= IDLE;
            busy_o   <= 1'b0;
          end else if (cnt == TO_LAST) begin
`ifdef XM_MEM_RETRY_EN
            if (!retried_q) begin
              retried_q <= 1'b1;
              cnt       <= '0;
              memReq_o  <= 1'b0;
            end else
`endif
            begin
              memReq_o  <= 1'b0;
              state     <= RESP;
              done_o    <= 1'b1;
              err_o     <= 1'b1;
              errCode_o <= ERR_TIMEOUT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
